// File: rtl/push_tick_pkg.sv
// Shared definitions for the push-button run/pause tick controller.
// Contents: FSM state encoding and default parameter values.
package push_tick_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   localparam int unsigned DEB_CYCLES_DEF  = 16;
   localparam int unsigned TICK_DIV_DEF    = 8;
   localparam int unsigned CNT_W_DEF       = 4;
   localparam int unsigned LONG_CYCLES_DEF = 64;

endpackage

// File: rtl/push_debounce.sv
// Button conditioner: 2-flop synchroniser, debounce counter and edge detect.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_push   raw asynchronous button level
//   o_level  debounced (stable) level
//   o_rise   one-cycle strobe when o_level goes 0->1
//   o_fall   one-cycle strobe when o_level goes 1->0
module push_debounce #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_push,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;
   logic [DW-1:0] r_cnt;
   logic          w_diff;
   logic          w_accept;

   assign w_diff   = (r_sync2 != r_level);
   // Synced level has disagreed with the stable level for DEB_CYCLES cycles.
   assign w_accept = w_diff && (r_cnt == DEB_MAX);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_push;
         r_sync2 <= r_sync1;
         r_rise  <= w_accept & r_sync2;
         r_fall  <= w_accept & ~r_sync2;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/push_tick_ctrl.sv
// Run/pause controller: a debounced push button steps an IDLE/RUN/PAUSE FSM; in RUN a
// prescaler emits o_tick every TICK_DIV cycles and advances a CNT_W-bit wrapping count.
// Optional feature macro LONG_PRESS_CLR_EN: press acts on release, and a hold of
// LONG_CYCLES clears everything back to IDLE without a release event.
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_push      raw button level
//   o_push_evt  one-cycle press action strobe
//   o_running   1 while in RUN
//   o_tick      one-cycle prescaler strobe (count already updated)
//   o_cnt       current count
//   o_wrap      one-cycle strobe with the tick that wraps o_cnt to 0
module push_tick_ctrl
   import push_tick_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   output logic             o_push_evt,
   output logic             o_running,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_wrap
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   if (DEB_CYCLES < 2) begin : g_deb_cfg_err
      $error("DEB_CYCLES must be >= 2");
   end
   if (TICK_DIV < 2) begin : g_div_cfg_err
      $error("TICK_DIV must be >= 2");
   end
   if (LONG_CYCLES < 2) begin : g_long_cfg_err
      $error("LONG_CYCLES must be >= 2");
   end

   state_t           r_state;
   state_t           w_state_d;
   logic [PW-1:0]    r_pre;
   logic [PW-1:0]    w_pre_d;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_tick;
   logic             w_tick_d;
   logic             r_wrap;
   logic             w_wrap_d;
   logic             w_level;
   logic             w_rise;
   logic             w_fall;
   logic             w_evt;
   logic             w_tick_now;

   push_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_push),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

`ifdef LONG_PRESS_CLR_EN
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] r_hold;
   logic          r_long;
   logic          w_long_hit;

   assign w_long_hit = w_level && !r_long && (r_hold == LONG_MAX);

   // r_long stays set until the level has dropped, masking that release's fall strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold <= '0;
         r_long <= 1'b0;
      end else if (!w_level) begin
         r_hold <= '0;
         r_long <= 1'b0;
      end else if (!r_long) begin
         r_hold <= r_hold + 1'b1;
         if (r_hold == LONG_MAX) begin
            r_long <= 1'b1;
         end
      end
   end

   // Rise and fall never coincide; the rise term is logically redundant.
   assign w_evt = w_fall & ~r_long & ~w_rise;
`else
   // A rise implies level=1 and excludes a fall; the extra terms are logically redundant.
   assign w_evt = w_rise & w_level & ~w_fall;
`endif

   assign w_tick_now = (r_state == ST_RUN) && (r_pre == PRE_MAX);

   always_comb begin
      w_state_d = r_state;
      w_pre_d   = r_pre;
      w_cnt_d   = r_cnt;
      w_tick_d  = 1'b0;
      w_wrap_d  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_evt) begin
               w_state_d = ST_RUN;
               w_pre_d   = '0;
            end
         end
         ST_RUN: begin
            // A tick on the same edge as the pause event still completes.
            if (w_tick_now) begin
               w_pre_d  = '0;
               w_cnt_d  = r_cnt + 1'b1;
               w_tick_d = 1'b1;
               w_wrap_d = &r_cnt;
            end else begin
               w_pre_d = r_pre + 1'b1;
            end
            if (w_evt) begin
               w_state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (w_evt) begin
               w_state_d = ST_RUN;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
`ifdef LONG_PRESS_CLR_EN
      if (w_long_hit) begin
         w_state_d = ST_IDLE;
         w_pre_d   = '0;
         w_cnt_d   = '0;
         w_tick_d  = 1'b0;
         w_wrap_d  = 1'b0;
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_pre   <= '0;
         r_cnt   <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_pre   <= w_pre_d;
         r_cnt   <= w_cnt_d;
         r_tick  <= w_tick_d;
         r_wrap  <= w_wrap_d;
      end
   end

   assign o_push_evt = w_evt;
   assign o_running  = (r_state == ST_RUN);
   assign o_tick     = r_tick;
   assign o_cnt      = r_cnt;
   assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_push_tick_ctrl.sv
// Directed bench for push_tick_ctrl (DEB_CYCLES=4, TICK_DIV=4, CNT_W=4, default build).
// Within each scenario, k numbers the clock edges; the input for edge k is driven just
// before it and outputs are sampled 1 time unit after it.
module tb_push_tick_ctrl;

   logic       clk;
   logic       rst;
   logic       push;
   logic       push_evt;
   logic       running;
   logic       tick;
   logic [3:0] cnt;
   logic       wrap;

   int tests_run;
   int tests_failed;

   push_tick_ctrl #(
      .DEB_CYCLES  (4),
      .TICK_DIV    (4),
      .CNT_W       (4),
      .LONG_CYCLES (16)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_push     (push),
      .o_push_evt (push_evt),
      .o_running  (running),
      .o_tick     (tick),
      .o_cnt      (cnt),
      .o_wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      push = 1'b0;
      repeat (3) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      rst  = 1'b1;
      push = 1'b0;
      repeat (6) step();
      tests_run++;
      if (running !== 1'b0) begin
         tests_failed++; $display("FAIL reset_running: got %b want 0", running);
      end
      tests_run++;
      if (tick !== 1'b0) begin
         tests_failed++; $display("FAIL reset_tick: got %b want 0", tick);
      end
      tests_run++;
      if (cnt !== 4'd0) begin
         tests_failed++; $display("FAIL reset_cnt: got %0d want 0", cnt);
      end
      tests_run++;
      if (wrap !== 1'b0 || push_evt !== 1'b0) begin
         tests_failed++; $display("FAIL reset_wrap_evt: got %b%b want 00", wrap, push_evt);
      end
      rst  = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (tick !== 1'b0 || running !== 1'b0 || push_evt !== 1'b0) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin
         tests_failed++; $display("FAIL reset_quiet: activity seen %b want 0", seen);
      end
   endtask

   task automatic test_bounce();
      logic evt_seen;
      logic run_seen;
      do_reset();
      evt_seen = 1'b0;
      run_seen = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         push = (k <= 12) ? (((k - 1) / 2) % 2 == 0) : 1'b0;
         step();
         if (push_evt !== 1'b0) evt_seen = 1'b1;
         if (running !== 1'b0) run_seen = 1'b1;
      end
      tests_run++;
      if (evt_seen !== 1'b0) begin
         tests_failed++; $display("FAIL bounce_evt: got %b want 0", evt_seen);
      end
      tests_run++;
      if (run_seen !== 1'b0 || cnt !== 4'd0) begin
         tests_failed++; $display("FAIL bounce_idle: running %b cnt %0d want 0 0", run_seen, cnt);
      end
   endtask

   task automatic test_press();
      logic       exp_tick;
      logic [3:0] exp_cnt;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         push = (k <= 10);
         step();
         if (k == 5 || k == 7) begin
            tests_run++;
            if (push_evt !== 1'b0) begin
               tests_failed++; $display("FAIL press_evt_k%0d: got %b want 0", k, push_evt);
            end
         end
         if (k == 6) begin
            tests_run++;
            if (push_evt !== 1'b1 || running !== 1'b0) begin
               tests_failed++;
               $display("FAIL press_evt_k6: evt %b running %b want 1 0", push_evt, running);
            end
         end
         if (k >= 7) begin
            exp_tick = (k >= 11) && ((k - 11) % 4 == 0);
            exp_cnt  = (k < 11) ? 4'd0 : 4'(1 + (k - 11) / 4);
            tests_run++;
            if (running !== 1'b1 || tick !== exp_tick || cnt !== exp_cnt) begin
               tests_failed++;
               $display("FAIL press_run_k%0d: run %b tick %b cnt %0d want 1 %b %0d",
                        k, running, tick, cnt, exp_tick, exp_cnt);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int         n;
      logic       bad_wrap;
      logic [3:0] exp_cnt;
      do_reset();
      n        = 0;
      bad_wrap = 1'b0;
      for (int k = 1; k <= 90; k++) begin
         push = (k <= 10);
         step();
         if (tick === 1'b1) begin
            n++;
            exp_cnt = 4'(n % 16);
            tests_run++;
            if (cnt !== exp_cnt || wrap !== (n == 16)) begin
               tests_failed++;
               $display("FAIL wrap_tick%0d: cnt %0d wrap %b want %0d %b",
                        n, cnt, wrap, exp_cnt, (n == 16));
            end
         end else if (wrap !== 1'b0) begin
            bad_wrap = 1'b1;
         end
         if (n == 16) break;
      end
      tests_run++;
      if (n != 16 || bad_wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_count: ticks %0d stray_wrap %b want 16 0", n, bad_wrap);
      end
   endtask

   // Press 2 lands on the edge that ticks 2->3; presses 4/5 pause and resume mid-phase.
   task automatic test_pause_tick();
      do_reset();
      for (int k = 1; k <= 60; k++) begin
         push = (k <= 5) || (k >= 13 && k <= 22) || (k >= 30 && k <= 34) ||
                (k >= 40 && k <= 44) || (k >= 50 && k <= 54);
         step();
         if (k == 18) begin
            tests_run++;
            if (push_evt !== 1'b1 || cnt !== 4'd2 || running !== 1'b1) begin
               tests_failed++;
               $display("FAIL pause_evt_k18: evt %b cnt %0d run %b want 1 2 1",
                        push_evt, cnt, running);
            end
         end
         if (k == 19) begin
            tests_run++;
            if (cnt !== 4'd3 || running !== 1'b0) begin
               tests_failed++;
               $display("FAIL pause_k19: cnt %0d run %b want 3 0", cnt, running);
            end
         end
         if (k == 25 || k == 50) begin
            tests_run++;
            if (cnt !== ((k == 25) ? 4'd3 : 4'd5) || running !== 1'b0 || tick !== 1'b0) begin
               tests_failed++;
               $display("FAIL pause_hold_k%0d: cnt %0d run %b tick %b", k, cnt, running, tick);
            end
         end
         if (k == 40 || k == 44) begin
            tests_run++;
            if (tick !== 1'b1 || cnt !== ((k == 40) ? 4'd4 : 4'd5)) begin
               tests_failed++;
               $display("FAIL resume_tick_k%0d: tick %b cnt %0d", k, tick, cnt);
            end
         end
         if (k == 57) begin
            tests_run++;
            if (running !== 1'b1 || tick !== 1'b0) begin
               tests_failed++;
               $display("FAIL phase_k57: run %b tick %b want 1 0", running, tick);
            end
         end
         if (k == 58) begin
            tests_run++;
            if (tick !== 1'b1 || cnt !== 4'd6) begin
               tests_failed++;
               $display("FAIL phase_k58: tick %b cnt %0d want 1 6", tick, cnt);
            end
         end
      end
   endtask

   task automatic test_reset_in_run();
      logic hit;
      logic active;
      do_reset();
      hit = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         push = (k <= 10);
         step();
         if (cnt === 4'd7 && running === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      tests_run++;
      if (hit !== 1'b1) begin
         tests_failed++; $display("FAIL rstrun_reach7: reached %b want 1", hit);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (cnt !== 4'd0 || running !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstrun_clear: cnt %0d run %b tick %b wrap %b want 0 0 0 0",
                  cnt, running, tick, wrap);
      end
      active = 1'b0;
      repeat (10) begin
         step();
         if (running !== 1'b0 || cnt !== 4'd0) active = 1'b1;
      end
      tests_run++;
      if (active !== 1'b0) begin
         tests_failed++; $display("FAIL rstrun_idle: activity %b want 0", active);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      push         = 1'b0;
      test_reset();
      test_bounce();
      test_press();
      test_wrap();
      test_pause_tick();
      test_reset_in_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
